nios_system_sysid_checker: RTL

Avalon-MM read master that interrogates the system-ID slave after reset or on request. It reads the ID word at address 0 and the timestamp word at address 1, and compares both against build-time expected values. It exposes captured values, a match flag and a timeout flag to the board-level status logic (LEDs, HEX display), so a mismatched or stale FPGA image is flagged before software runs.

---
 rtl/nios_system_sysid_pkg.sv | 28 ++
 rtl/nios_system_sysid_checker_if.sv | 23 ++
 rtl/nios_system_sysid_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/nios_system_sysid_pkg.sv
// rtl/nios_system_sysid_pkg.sv - shared types and constants for the sysid checker and sysid slave
package nios_system_sysid_pkg;

  localparam int CNT_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    FIN
  } sysid_state_t;

  function automatic logic sysid_match(
    input logic [31:0] id,
    input logic [31:0] ts,
    input logic [31:0] exp_id,
    input logic [31:0] exp_ts,
    input logic        check_ts
  );
    return (id == exp_id) && (!check_ts || (ts == exp_ts));
  endfunction

endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// rtl/nios_system_sysid_checker_if.sv - Avalon-MM read port between the checker and the sysid slave
interface nios_system_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/nios_system_sysid_checker.sv
// rtl/nios_system_sysid_checker.sv - reads sysid ID/timestamp words and flags image mismatch or slave timeout
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h0000_0000,
  parameter int          CHECK_TS     = 1,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  nios_system_sysid_checker_if.master avm,
  output logic                        busy,
  output logic                        done,
  output logic                        match,
  output logic                        timeout,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               HAS_LAT  = (READ_LATENCY != 0);

  sysid_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr, cnt_inc, cap_id, cap_ts, eval, abort, clr_flags;
  logic             rd_c, addr_c;
  logic [31:0]      id_d, ts_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One counter serves both stall timeout (RD_*) and latency wait (LAT_*).
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    eval      = 1'b0;
    abort     = 1'b0;
    clr_flags = 1'b0;
    rd_c      = 1'b0;
    addr_c    = SYSID_ADDR_ID;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          clr_flags = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      RD_ID: begin
        rd_c = 1'b1;
        if (!avm.avm_waitrequest) begin
          cnt_clr = 1'b1;
          if (HAS_LAT) begin
            state_d = LAT_ID;
          end else begin
            cap_id  = 1'b1;
            state_d = RD_TS;
          end
        end else if (cnt_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      LAT_ID: begin
        if (cnt_q == LAT_LAST) begin
          cap_id  = 1'b1;
          cnt_clr = 1'b1;
          state_d = RD_TS;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RD_TS: begin
        rd_c   = 1'b1;
        addr_c = SYSID_ADDR_TS;
        if (!avm.avm_waitrequest) begin
          cnt_clr = 1'b1;
          if (HAS_LAT) begin
            state_d = LAT_TS;
          end else begin
            cap_ts  = 1'b1;
            eval    = 1'b1;
            state_d = FIN;
          end
        end else if (cnt_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      LAT_TS: begin
        addr_c = SYSID_ADDR_TS;
        if (cnt_q == LAT_LAST) begin
          cap_ts  = 1'b1;
          eval    = 1'b1;
          cnt_clr = 1'b1;
          state_d = FIN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign id_d = cap_id ? avm.avm_readdata : id_value;
  assign ts_d = cap_ts ? avm.avm_readdata : ts_value;

  // Match is resolved on the edge entering FIN so it is valid alongside done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      id_value <= '0;
      ts_value <= '0;
      match    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      id_value <= id_d;
      ts_value <= ts_d;
      if (clr_flags) begin
        match   <= 1'b0;
        timeout <= 1'b0;
      end else if (abort) begin
        match   <= 1'b0;
        timeout <= 1'b1;
      end else if (eval) begin
        match <= sysid_match(id_d, ts_d, EXPECTED_ID, EXPECTED_TS, CHECK_TS != 0);
      end
    end
  end

  assign avm.avm_read    = rd_c;
  assign avm.avm_address = addr_c;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FIN);

endmodule
